// File: rtl/edl_mem_stream_reader.sv
// Avalon-MM block read master feeding an Avalon-ST source through a small output FIFO.
// Define EDL_MEM_READER_PKT_EN to add out_startofpacket/out_endofpacket.
//
// state | meaning
// IDLE  | waiting for start; a zero word_count start only pulses done
// RUN   | issuing one read per cycle while the FIFO has room for it
// DRAIN | all reads issued; waiting for the last word to be accepted
module edl_mem_stream_reader #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
`ifdef EDL_MEM_READER_PKT_EN
   output logic              out_startofpacket,
   output logic              out_endofpacket,
`endif
   input  logic              out_ready
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = PTR_W + 1;
`ifdef EDL_MEM_READER_PKT_EN
   localparam int ENT_W  = DATA_W + 2;
`else
   localparam int ENT_W  = DATA_W;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // reset asserts asynchronously but releases in step with clk
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   state_t              state_q, state_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                cs_q, cs_d, pend_q, pend_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    rem_q, rem_d, acc_q, acc_d;
   logic [ENT_W-1:0]    fifo_q [FIFO_DEPTH];
   logic [ENT_W-1:0]    fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   cnt_q, cnt_d;
   logic [FCNT_W:0]     fill;
   logic                can_issue, pop;
   logic [ENT_W-1:0]    entry, head;
`ifdef EDL_MEM_READER_PKT_EN
   logic                cs_sop_q, cs_sop_d, cs_eop_q, cs_eop_d;
   logic                pend_sop_q, pend_sop_d, pend_eop_q, pend_eop_d;
   assign entry = {pend_eop_q, pend_sop_q, mem_readdata};
`else
   assign entry = mem_readdata;
`endif

   assign head = fifo_q[rd_ptr_q];
   assign pop  = (cnt_q != '0) && out_ready;

   // slots already claimed (buffered, in flight, being issued) after this cycle's pop
   assign fill      = {1'b0, cnt_q} + (FCNT_W+1)'(pend_q) + (FCNT_W+1)'(cs_q) - (FCNT_W+1)'(pop);
   assign can_issue = fill < (FCNT_W+1)'(FIFO_DEPTH);

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cs_d     = 1'b0;
      addr_d   = addr_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      pend_d   = cs_q;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + FCNT_W'(pend_q) - FCNT_W'(pop);
`ifdef EDL_MEM_READER_PKT_EN
      cs_sop_d   = 1'b0;
      cs_eop_d   = 1'b0;
      pend_sop_d = cs_sop_q;
      pend_eop_d = cs_eop_q;
`endif
      if (pend_q) begin
         fifo_d[wr_ptr_q] = entry;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         acc_d    = acc_q - CNT_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  cs_d    = 1'b1;
                  addr_d  = start_addr;
                  rem_d   = word_count - CNT_W'(1);
                  acc_d   = word_count;
                  state_d = (word_count == CNT_W'(1)) ? DRAIN : RUN;
`ifdef EDL_MEM_READER_PKT_EN
                  cs_sop_d = 1'b1;
                  cs_eop_d = (word_count == CNT_W'(1));
`endif
               end
            end
         end
         RUN: begin
            if (can_issue) begin
               cs_d   = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = DRAIN;
`ifdef EDL_MEM_READER_PKT_EN
               cs_eop_d = (rem_q == CNT_W'(1));
`endif
            end
         end
         DRAIN: begin
            if (pop && acc_q == CNT_W'(1)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cs_q     <= 1'b0;
         pend_q   <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         acc_q    <= '0;
         fifo_q   <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
`ifdef EDL_MEM_READER_PKT_EN
         cs_sop_q   <= 1'b0;
         cs_eop_q   <= 1'b0;
         pend_sop_q <= 1'b0;
         pend_eop_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cs_q     <= cs_d;
         pend_q   <= pend_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         acc_q    <= acc_d;
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
`ifdef EDL_MEM_READER_PKT_EN
         cs_sop_q   <= cs_sop_d;
         cs_eop_q   <= cs_eop_d;
         pend_sop_q <= pend_sop_d;
         pend_eop_q <= pend_eop_d;
`endif
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign mem_address    = addr_q;
   assign mem_chipselect = cs_q;
   assign out_valid      = (cnt_q != '0);
   assign out_data       = head[DATA_W-1:0];
`ifdef EDL_MEM_READER_PKT_EN
   assign out_startofpacket = head[DATA_W];
   assign out_endofpacket   = head[DATA_W+1];
`endif

endmodule
